// File: rtl/bus_sram_slave_pkg.sv
// Shared definitions for the bus SRAM responder: window geometry and FSM state encoding.
package bus_sram_slave_pkg;

  localparam int WINDOW_WORDS = 512;
  localparam int INDEX_W      = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_READ_END,
    ST_WRITE,
    ST_ERROR,
    ST_ERROR_WAIT
  } state_t;

endpackage

// File: rtl/bus_sram_slave_mem.sv
// True dual-port 512x32 SRAM: port A has a per-byte write mask, port B is a full-word local port.
module bus_sram_slave_mem
  import bus_sram_slave_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] addr_a,
  input  logic [3:0]         we_a,
  input  logic [31:0]        din_a,
  output logic [31:0]        q_a,
  input  logic [INDEX_W-1:0] addr_b,
  input  logic               we_b,
  input  logic [31:0]        din_b,
  output logic [31:0]        q_b
);

  logic [31:0] mem [WINDOW_WORDS];

  // Port A is applied after port B so bus bytes win if both hit one word.
  always_ff @(posedge clk) begin
    if (we_b) begin
      mem[addr_b] <= din_b;
    end
    for (int i = 0; i < 4; i++) begin
      if (we_a[i]) begin
        mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// Burst bus responder over a 512x32 SRAM window with a local direct port.
// Optional per-transaction byte enables: define BUS_SRAM_SLAVE_BYTE_ENABLE_EN.
module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter logic [31:0] baseAddress = 32'h5000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               beginTransactionIn,
  input  logic               readNotWriteIn,
  input  logic [3:0]         byteEnablesIn,
  input  logic [7:0]         burstSizeIn,
  input  logic [31:0]        addressDataIn,
  input  logic               dataValidIn,
  input  logic               endTransactionIn,
  input  logic               busyIn,
  output logic [31:0]        addressDataOut,
  output logic               dataValidOut,
  output logic               endTransactionOut,
  output logic               busErrorOut,
  output logic               busyOut,
  input  logic [INDEX_W-1:0] localAddress,
  input  logic               localWriteEnable,
  input  logic [31:0]        localDataIn,
  output logic [31:0]        localDataOut
);

  state_t             state_reg, state_next;
  logic [INDEX_W-1:0] index_reg, index_next;
  logic [INDEX_W-1:0] count_reg, count_next;
  logic               rnw_reg, rnw_next;
  logic               done_reg, done_next;
  logic               dv_reg, dv_next;
  logic               end_reg, end_next;
  logic               err_reg, err_next;
  logic               selected, range_err;
  logic [INDEX_W-1:0] start_index;
  logic [3:0]         wr_mask, mem_we;
  logic               local_we;
  logic [31:0]        q_a;
  logic               unused_inputs;

`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
  logic [3:0] be_reg, be_next;
  assign wr_mask       = be_reg;
  assign unused_inputs = ^{busyIn, addressDataIn[1:0]};
`else
  assign wr_mask       = 4'hF;
  assign unused_inputs = ^{busyIn, addressDataIn[1:0], byteEnablesIn};
`endif

  assign selected    = beginTransactionIn && (addressDataIn[31:11] == baseAddress[31:11]);
  assign start_index = addressDataIn[10:2];

  always_comb begin
    range_err = ({1'b0, start_index} + {2'b00, burstSizeIn}) > 10'd511;
`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
    if (byteEnablesIn == 4'b0000) range_err = 1'b1;
`endif
  end

  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    count_next = count_reg;
    rnw_next   = rnw_reg;
    done_next  = done_reg;
`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
    be_next    = be_reg;
`endif
    dv_next    = 1'b0;
    end_next   = 1'b0;
    err_next   = 1'b0;
    mem_we     = 4'b0000;
    case (state_reg)
      ST_IDLE: begin
        if (selected) begin
          rnw_next   = readNotWriteIn;
          index_next = start_index;
          count_next = {1'b0, burstSizeIn};
          done_next  = 1'b0;
`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
          be_next    = byteEnablesIn;
`endif
          if (range_err) begin
            err_next   = 1'b1;
            state_next = ST_ERROR;
          end else begin
            state_next = readNotWriteIn ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        dv_next    = 1'b1;
        index_next = index_reg + 9'd1;
        count_next = count_reg - 9'd1;
        if (count_reg == '0) state_next = ST_READ_END;
      end
      ST_READ_END: begin
        end_next   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_WRITE: begin
        if (dataValidIn) begin
          if (done_reg) begin
            err_next = 1'b1;
          end else begin
            mem_we = wr_mask;
            // The final in-range word marks the burst full instead of wrapping.
            if (count_reg == '0) begin
              done_next = 1'b1;
            end else begin
              count_next = count_reg - 9'd1;
              index_next = index_reg + 9'd1;
            end
          end
        end
        if (endTransactionIn) state_next = ST_IDLE;
      end
      ST_ERROR: begin
        end_next   = 1'b1;
        state_next = (rnw_reg || endTransactionIn) ? ST_IDLE : ST_ERROR_WAIT;
      end
      ST_ERROR_WAIT: begin
        if (endTransactionIn) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      index_reg <= '0;
      count_reg <= '0;
      rnw_reg   <= 1'b0;
      done_reg  <= 1'b0;
      dv_reg    <= 1'b0;
      end_reg   <= 1'b0;
      err_reg   <= 1'b0;
`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
      be_reg    <= 4'b0000;
`endif
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      count_reg <= count_next;
      rnw_reg   <= rnw_next;
      done_reg  <= done_next;
      dv_reg    <= dv_next;
      end_reg   <= end_next;
      err_reg   <= err_next;
`ifdef BUS_SRAM_SLAVE_BYTE_ENABLE_EN
      be_reg    <= be_next;
`endif
    end
  end

  // Bus write owns a shared index; the colliding local write is dropped.
  assign local_we = localWriteEnable && !((|mem_we) && (localAddress == index_reg));

  bus_sram_slave_mem u_mem (
    .clk    (clock),
    .rst    (reset),
    .addr_a (index_reg),
    .we_a   (mem_we),
    .din_a  (addressDataIn),
    .q_a    (q_a),
    .addr_b (localAddress),
    .we_b   (local_we),
    .din_b  (localDataIn),
    .q_b    (localDataOut)
  );

  assign addressDataOut    = dv_reg ? q_a : 32'h0;
  assign dataValidOut      = dv_reg;
  assign endTransactionOut = end_reg;
  assign busErrorOut       = err_reg;
  assign busyOut           = 1'b0;

endmodule
